elevator_request_scheduler: RTL and testbench
=============================================

Name: elevator_request_scheduler

Overview:
- Collects floor calls from hall and car buttons and holds them as a pending set.
- Runs collective up/down (SCAN) servicing and issues one target floor at a time to the car motion controller.
- Sequences door dwell and blocks departure while the car is over weight.
- Sits between the button-panel synchroniser and the car controller; the car controller reports current_floor.

Parameters:
NUM_FLOORS, 9, number of served floors (0..NUM_FLOORS-1); legal range 2..16
FLOOR_W, 4, width of floor numbers
DOOR_CYCLES, 4, door-open dwell in clk cycles; must be >= 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
call_req  input  NUM_FLOORS  one-cycle pulses; bit i = call for floor i; several bits may be set in one cycle
current_floor  input  FLOOR_W  floor the car is at, from the car controller; changes by at most 1 per cycle
over_weight  input  1  load sensor; level
target_floor  output  FLOOR_W  floor the car must travel to
target_valid  output  1  target_floor is meaningful; car moves only while high
dir_up  output  1  committed direction is up
dir_down  output  1  committed direction is down
door_open  output  1  door command
weight_alert  output  1  over_weight seen while departure is blocked
pending  output  NUM_FLOORS  registered outstanding calls

Behaviour:
- All outputs are registered.
- Reset values: pending=0, target_floor=0, target_valid=0, dir_up=0, dir_down=0, door_open=0, weight_alert=0, state=IDLE, dwell counter=0.
- Reset mid-operation drops all calls immediately (next edge).
- Pending update each cycle: pending <= (pending | call_req) & ~clear_mask. clear_mask is the bit for current_floor on the cycle DOOR_OPEN is entered, and 0 otherwise. Bits >= NUM_FLOORS do not exist.
- A call on the floor being cleared in the same cycle: clear wins, and the dwell counter is reloaded.
- Call latency: a call pulse at edge n appears in pending after edge n.
- States are IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- IDLE (dir_up=dir_down=0, target_valid=0):
  - pending bit at current_floor set -> DOOR_OPEN.
  - else any pending above -> MOVE_UP, target = nearest pending above.
  - else any pending below -> MOVE_DOWN, target = nearest pending below.
  - over_weight=1 blocks leaving IDLE toward MOVE_*; weight_alert=1 while blocked. DOOR_OPEN entry is still allowed.
- MOVE_UP (dir_up=1, target_valid=1):
  - target is recomputed every cycle as the nearest pending floor strictly above current_floor, so calls arriving in the direction of travel are picked up en route.
  - current_floor == target_floor -> DOOR_OPEN, clear that pending bit, target_valid=0.
- MOVE_DOWN: mirror of MOVE_UP (dir_down=1, nearest pending below).
- DOOR_OPEN:
  - door_open=1 and target_valid=0; the dwell counter loads DOOR_CYCLES-1 on entry and decrements.
  - over_weight=1 reloads the counter every cycle it is high and sets weight_alert=1. weight_alert falls on the first cycle over_weight is low.
  - counter==0 with over_weight=0 closes the door. Next state, keeping the current direction if possible:
    - pending ahead in the current direction -> same MOVE state.
    - else pending behind -> reverse MOVE state.
    - else -> IDLE.
  - Direction on DOOR_OPEN entered from IDLE: choose up first.
- Direction is never both up and down; dir_up/dir_down stay asserted through DOOR_OPEN when entered from MOVE.
- Width rules: floor compares are unsigned FLOOR_W. current_floor >= NUM_FLOORS is illegal; hold the current state and keep target_valid=0.

Decomposition:
- Package elevator_pkg:
  - state enum {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN}
  - direction enum {DIR_NONE, DIR_UP, DIR_DOWN}
  - default NUM_FLOORS / FLOOR_W constants shared with the car controller.
- Sub-module elevator_next_floor_sel (combinational): given pending and current_floor, returns found_above, nearest_above, found_below, nearest_below, at_current. It is instantiated once.

Test Plan:
- Reset mid-MOVE_UP, with pending=9'b1_0000_0100 → after one edge: pending=0, state IDLE, all outputs 0.
- From IDLE at floor 0, pulse call_req[5]; a car model steps one floor per cycle → target_valid=1 with target 5 two cycles after the pulse; dir_up=1. At floor 5: door_open=1 for exactly 4 cycles, pending[5]=0, then IDLE.
- Car moving up from 1 toward 6, call_req[3] pulsed while at floor 2 → target switches to 3. The car stops at 3 (4-cycle dwell), then continues to 6.
- At floor 4 with pending floors 6 and 1, going up → service order is 6 then 1. dir_down asserts after the dwell at 6.
- over_weight held for 10 cycles during DOOR_OPEN at floor 2 → door_open stays 1 and weight_alert=1 throughout. The door closes 4 cycles after over_weight falls.
- call_req[current_floor] pulsed on the DOOR_OPEN entry cycle → bit not left pending, dwell restarted.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator request scheduler and the car controller.
package elevator_pkg;

    localparam int NUM_FLOORS_DEFAULT  = 9;
    localparam int FLOOR_W_DEFAULT     = 4;
    localparam int DOOR_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN
    } dir_t;

endpackage

// File: rtl/elevator_next_floor_sel.sv
// Combinational search of the pending set relative to the car position:
// nearest call strictly above, nearest call strictly below, and a call at the current floor.
module elevator_next_floor_sel #(
    parameter int NUM_FLOORS = 9,
    parameter int FLOOR_W    = 4
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  found_above,
    output logic [FLOOR_W-1:0]    nearest_above,
    output logic                  found_below,
    output logic [FLOOR_W-1:0]    nearest_below,
    output logic                  at_current
);

    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] here_mask;

    // Classify every pending floor as above, below or at the car.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_classify
        assign above_mask[gi] = pending[gi] && (FLOOR_W'(gi) > current_floor);
        assign below_mask[gi] = pending[gi] && (FLOOR_W'(gi) < current_floor);
        assign here_mask[gi]  = pending[gi] && (FLOOR_W'(gi) == current_floor);
    end

    assign found_above = |above_mask;
    assign found_below = |below_mask;
    assign at_current  = |here_mask;

    // Lowest set floor in the above mask (scan downward so the last hit wins).
    always_comb begin
        nearest_above = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above_mask[i]) nearest_above = FLOOR_W'(i);
        end
    end

    // Highest set floor in the below mask (scan upward so the last hit wins).
    always_comb begin
        nearest_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below_mask[i]) nearest_below = FLOOR_W'(i);
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Collective up/down (SCAN) elevator scheduler: latches floor calls, issues one
// target floor at a time, sequences the door dwell and holds the car while overloaded.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W     = FLOOR_W_DEFAULT,
    parameter int DOOR_CYCLES = DOOR_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  over_weight,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  dir_up,
    output logic                  dir_down,
    output logic                  door_open,
    output logic                  weight_alert,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int                  DWELL_W     = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [DWELL_W-1:0]  DWELL_LOAD  = DWELL_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W:0]    FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

    state_t                state_reg, state_next;
    logic [NUM_FLOORS-1:0] pending_reg, pending_next;
    logic [FLOOR_W-1:0]    target_reg, target_next;
    logic                  target_valid_reg, target_valid_next;
    logic                  dir_up_reg, dir_down_reg;
    dir_t                  dir_cur, dir_next;
    logic                  door_open_reg, door_open_next;
    logic                  weight_alert_reg, weight_alert_next;
    logic [DWELL_W-1:0]    dwell_reg, dwell_next;

    logic                  found_above, found_below, at_current;
    logic [FLOOR_W-1:0]    nearest_above, nearest_below;
    logic [NUM_FLOORS-1:0] cur_onehot;
    logic                  floor_legal;
    logic                  clear_en;
    logic                  prefer_up, take_up, take_down;

    elevator_next_floor_sel #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_sel (
        .pending       (pending_reg),
        .current_floor (current_floor),
        .found_above   (found_above),
        .nearest_above (nearest_above),
        .found_below   (found_below),
        .nearest_below (nearest_below),
        .at_current    (at_current)
    );

    // One-hot of the car position, used to clear the serviced call.
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_onehot
        assign cur_onehot[gi] = (FLOOR_W'(gi) == current_floor);
    end

    assign floor_legal = ({1'b0, current_floor} < FLOOR_LIMIT);
    assign dir_cur     = dir_up_reg ? DIR_UP : (dir_down_reg ? DIR_DOWN : DIR_NONE);

    // Keep going the committed way when possible; with no direction, up is tried first.
    assign prefer_up = (dir_cur != DIR_DOWN);
    assign take_up   = found_above && (prefer_up || !found_below);
    assign take_down = found_below && !take_up;

    // Next-state, target and door sequencing.
    always_comb begin
        state_next        = state_reg;
        target_next       = target_reg;
        target_valid_next = 1'b0;
        dir_next          = dir_cur;
        door_open_next    = 1'b0;
        weight_alert_next = 1'b0;
        dwell_next        = dwell_reg;
        clear_en          = 1'b0;

        if (!floor_legal) begin
            // Bad position report: freeze everything and stop the car.
            door_open_next    = door_open_reg;
            weight_alert_next = weight_alert_reg;
        end else begin
            case (state_reg)
                IDLE: begin
                    dir_next = DIR_NONE;
                    if (at_current) begin
                        state_next     = DOOR_OPEN;
                        clear_en       = 1'b1;
                        dwell_next     = DWELL_LOAD;
                        door_open_next = 1'b1;
                    end else if (found_above || found_below) begin
                        if (over_weight) begin
                            weight_alert_next = 1'b1;
                        end else if (take_up) begin
                            state_next        = MOVE_UP;
                            target_next       = nearest_above;
                            target_valid_next = 1'b1;
                            dir_next          = DIR_UP;
                        end else begin
                            state_next        = MOVE_DOWN;
                            target_next       = nearest_below;
                            target_valid_next = 1'b1;
                            dir_next          = DIR_DOWN;
                        end
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (current_floor == target_reg) begin
                        state_next     = DOOR_OPEN;
                        clear_en       = 1'b1;
                        dwell_next     = DWELL_LOAD;
                        door_open_next = 1'b1;
                    end else if (state_reg == MOVE_UP && found_above) begin
                        target_next       = nearest_above;
                        target_valid_next = 1'b1;
                    end else if (state_reg == MOVE_DOWN && found_below) begin
                        target_next       = nearest_below;
                        target_valid_next = 1'b1;
                    end else begin
                        // Nothing left ahead: give up the trip rather than drive blind.
                        state_next = IDLE;
                        dir_next   = DIR_NONE;
                    end
                end
                DOOR_OPEN: begin
                    door_open_next = 1'b1;
                    if (over_weight) begin
                        dwell_next        = DWELL_LOAD;
                        weight_alert_next = 1'b1;
                    end else if (dwell_reg != '0) begin
                        dwell_next = dwell_reg - DWELL_W'(1);
                    end else begin
                        door_open_next = 1'b0;
                        if (take_up) begin
                            state_next        = MOVE_UP;
                            target_next       = nearest_above;
                            target_valid_next = 1'b1;
                            dir_next          = DIR_UP;
                        end else if (take_down) begin
                            state_next        = MOVE_DOWN;
                            target_next       = nearest_below;
                            target_valid_next = 1'b1;
                            dir_next          = DIR_DOWN;
                        end else begin
                            state_next = IDLE;
                            dir_next   = DIR_NONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    dir_next   = DIR_NONE;
                end
            endcase
        end

        // A call on the floor being opened in the same cycle is absorbed by the clear.
        pending_next = (pending_reg | call_req) & ~(clear_en ? cur_onehot : '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            pending_reg      <= '0;
            target_reg       <= '0;
            target_valid_reg <= 1'b0;
            dir_up_reg       <= 1'b0;
            dir_down_reg     <= 1'b0;
            door_open_reg    <= 1'b0;
            weight_alert_reg <= 1'b0;
            dwell_reg        <= '0;
        end else begin
            state_reg        <= state_next;
            pending_reg      <= pending_next;
            target_reg       <= target_next;
            target_valid_reg <= target_valid_next;
            dir_up_reg       <= (dir_next == DIR_UP);
            dir_down_reg     <= (dir_next == DIR_DOWN);
            door_open_reg    <= door_open_next;
            weight_alert_reg <= weight_alert_next;
            dwell_reg        <= dwell_next;
        end
    end

    assign target_floor = target_reg;
    assign target_valid = target_valid_reg;
    assign dir_up       = dir_up_reg;
    assign dir_down     = dir_down_reg;
    assign door_open    = door_open_reg;
    assign weight_alert = weight_alert_reg;
    assign pending      = pending_reg;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// per-cycle behavioural model of the scheduling rules, with a one-floor-per-cycle car.
module tb_elevator_request_scheduler;

    localparam int NF = 9;
    localparam int FW = 4;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic [FW-1:0] current_floor;
    logic          over_weight;
    logic [FW-1:0] target_floor;
    logic          target_valid;
    logic          dir_up;
    logic          dir_down;
    logic          door_open;
    logic          weight_alert;
    logic [NF-1:0] pending;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: mode 0 idle, 1 up, 2 down, 3 door open.
    bit m_pend [NF];
    int m_mode, m_tgt, m_cnt;
    bit m_tv, m_up, m_dn, m_door, m_wa;

    elevator_request_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .current_floor (current_floor),
        .over_weight   (over_weight),
        .target_floor  (target_floor),
        .target_valid  (target_valid),
        .dir_up        (dir_up),
        .dir_down      (dir_down),
        .door_open     (door_open),
        .weight_alert  (weight_alert),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int f = 0; f < NF; f++) m_pend[f] = 1'b0;
        m_mode = 0; m_tgt = 0; m_cnt = 0;
        m_tv = 0; m_up = 0; m_dn = 0; m_door = 0; m_wa = 0;
    endfunction

    function automatic logic [NF-1:0] pend_vec();
        logic [NF-1:0] v;
        v = '0;
        for (int f = 0; f < NF; f++) v[f] = m_pend[f];
        return v;
    endfunction

    // One clock of the scheduling rules, decided on the pre-edge pending set.
    function automatic void model_step(input logic [NF-1:0] c, input bit ow, input int cur);
        int na, nb, nxt, n_mode, n_tgt, n_cnt;
        bit here, clr, n_tv, n_up, n_dn, n_door, n_wa;
        na = -1; nb = -1; here = 0; clr = 0;
        for (int f = NF - 1; f > cur; f--) if (m_pend[f]) na = f;
        for (int f = 0; f < cur && f < NF; f++) if (m_pend[f]) nb = f;
        if (cur < NF) here = m_pend[cur];
        n_mode = m_mode; n_tgt = m_tgt; n_cnt = m_cnt;
        n_tv = 0; n_up = m_up; n_dn = m_dn; n_door = 0; n_wa = 0;
        if (cur >= NF) begin
            n_door = m_door; n_wa = m_wa;
        end else if (m_mode == 0) begin
            n_up = 0; n_dn = 0;
            if (here) begin
                n_mode = 3; clr = 1; n_cnt = DC - 1; n_door = 1;
            end else if (na >= 0 || nb >= 0) begin
                if (ow) n_wa = 1;
                else if (na >= 0) begin n_mode = 1; n_tgt = na; n_tv = 1; n_up = 1; end
                else begin n_mode = 2; n_tgt = nb; n_tv = 1; n_dn = 1; end
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            nxt = (m_mode == 1) ? na : nb;
            if (cur == m_tgt) begin
                n_mode = 3; clr = 1; n_cnt = DC - 1; n_door = 1;
            end else if (nxt >= 0) begin
                n_tgt = nxt; n_tv = 1;
            end else begin
                n_mode = 0; n_up = 0; n_dn = 0;
            end
        end else begin
            n_door = 1;
            if (ow) begin n_cnt = DC - 1; n_wa = 1; end
            else if (m_cnt > 0) n_cnt = m_cnt - 1;
            else begin
                n_door = 0;
                if (na >= 0 && (!m_dn || nb < 0)) begin n_mode = 1; n_tgt = na; n_tv = 1; n_up = 1; n_dn = 0; end
                else if (nb >= 0) begin n_mode = 2; n_tgt = nb; n_tv = 1; n_up = 0; n_dn = 1; end
                else begin n_mode = 0; n_up = 0; n_dn = 0; end
            end
        end
        for (int f = 0; f < NF; f++) m_pend[f] = (m_pend[f] | c[f]) && !(clr && f == cur);
        m_mode = n_mode; m_tgt = n_tgt; m_cnt = n_cnt;
        m_tv = n_tv; m_up = n_up; m_dn = n_dn; m_door = n_door; m_wa = n_wa;
    endfunction

    // Drive one cycle, advance the model, then let the car move one floor toward the model's target.
    task automatic tick(input logic [NF-1:0] c, input logic ow, input logic rst);
        call_req = c; over_weight = ow; reset = rst;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(c, ow, int'(current_floor));
        #1;
        call_req = '0; reset = 1'b0;
        if (!rst && m_tv) begin
            if (int'(current_floor) < m_tgt) current_floor = current_floor + 4'd1;
            else if (int'(current_floor) > m_tgt) current_floor = current_floor - 4'd1;
        end
    endtask

    task automatic run_until_door(input logic want);
        for (int k = 0; k < 40 && door_open !== want; k++) tick('0, 1'b0, 1'b0);
    endtask

    task automatic start_at(input logic [FW-1:0] floor);
        current_floor = floor;
        tick('0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        start_at(4'd0);
        n_cmp++;
        if ({target_floor, target_valid, dir_up, dir_down, door_open, weight_alert, pending} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tgt=%0d tv=%b up=%b dn=%b door=%b wa=%b pend=%h required all zero",
                     target_floor, target_valid, dir_up, dir_down, door_open, weight_alert, pending);
        end
    endtask

    task automatic test_single_call();
        int cnt;
        start_at(4'd0);
        tick(9'h020, 1'b0, 1'b0);
        n_cmp++;
        if (pending !== 9'h020 || target_valid !== 1'b0) begin
            n_fail++; $display("FAIL call_latency: got pend=%h tv=%b required pend=020 tv=0", pending, target_valid);
        end
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_valid !== 1'b1 || target_floor !== 4'd5 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL first_target: got tv=%b tgt=%0d up=%b required 1/5/1", target_valid, target_floor, dir_up);
        end
        run_until_door(1'b1);
        n_cmp++;
        if (door_open !== 1'b1 || current_floor !== 4'd5 || pending !== 9'h000) begin
            n_fail++; $display("FAIL arrive_5: got door=%b floor=%0d pend=%h required 1/5/000", door_open, current_floor, pending);
        end
        cnt = 1;
        for (int k = 0; k < 20 && door_open === 1'b1; k++) begin
            tick('0, 1'b0, 1'b0);
            if (door_open === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt !== DC) begin
            n_fail++; $display("FAIL dwell_len: got %0d cycles required %0d", cnt, DC);
        end
        n_cmp++;
        if (target_valid !== 1'b0 || dir_up !== 1'b0 || dir_down !== 1'b0) begin
            n_fail++; $display("FAIL back_to_idle: got tv=%b up=%b dn=%b required 0/0/0", target_valid, dir_up, dir_down);
        end
    endtask

    task automatic test_enroute();
        start_at(4'd1);
        tick(9'h040, 1'b0, 1'b0);
        tick(9'h008, 1'b0, 1'b0);
        n_cmp++;
        if (target_floor !== 4'd6 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL enroute_start: got tgt=%0d up=%b required 6/1", target_floor, dir_up);
        end
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_floor !== 4'd3 || target_valid !== 1'b1) begin
            n_fail++; $display("FAIL enroute_switch: got tgt=%0d tv=%b required 3/1", target_floor, target_valid);
        end
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (door_open !== 1'b1 || current_floor !== 4'd3 || pending !== 9'h040) begin
            n_fail++; $display("FAIL enroute_stop3: got door=%b floor=%0d pend=%h required 1/3/040", door_open, current_floor, pending);
        end
        run_until_door(1'b0);
        n_cmp++;
        if (target_floor !== 4'd6 || target_valid !== 1'b1 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL enroute_resume: got tgt=%0d tv=%b up=%b required 6/1/1", target_floor, target_valid, dir_up);
        end
        run_until_door(1'b1);
        n_cmp++;
        if (current_floor !== 4'd6 || door_open !== 1'b1) begin
            n_fail++; $display("FAIL enroute_stop6: got floor=%0d door=%b required 6/1", current_floor, door_open);
        end
    endtask

    task automatic test_reverse();
        start_at(4'd4);
        tick(9'h042, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_floor !== 4'd6 || dir_up !== 1'b1) begin
            n_fail++; $display("FAIL reverse_first: got tgt=%0d up=%b required 6/1", target_floor, dir_up);
        end
        run_until_door(1'b1);
        n_cmp++;
        if (current_floor !== 4'd6 || dir_up !== 1'b1 || dir_down !== 1'b0) begin
            n_fail++; $display("FAIL reverse_at6: got floor=%0d up=%b dn=%b required 6/1/0", current_floor, dir_up, dir_down);
        end
        run_until_door(1'b0);
        n_cmp++;
        if (dir_down !== 1'b1 || dir_up !== 1'b0 || target_floor !== 4'd1) begin
            n_fail++; $display("FAIL reverse_turn: got dn=%b up=%b tgt=%0d required 1/0/1", dir_down, dir_up, target_floor);
        end
        run_until_door(1'b1);
        n_cmp++;
        if (current_floor !== 4'd1 || pending !== 9'h000) begin
            n_fail++; $display("FAIL reverse_at1: got floor=%0d pend=%h required 1/000", current_floor, pending);
        end
    endtask

    task automatic test_over_weight();
        start_at(4'd0);
        tick(9'h008, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0);
        n_cmp++;
        if (target_valid !== 1'b0 || weight_alert !== 1'b1) begin
            n_fail++; $display("FAIL idle_blocked: got tv=%b wa=%b required 0/1", target_valid, weight_alert);
        end
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_valid !== 1'b1 || weight_alert !== 1'b0) begin
            n_fail++; $display("FAIL idle_release: got tv=%b wa=%b required 1/0", target_valid, weight_alert);
        end
        start_at(4'd2);
        tick(9'h004, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick('0, 1'b1, 1'b0);
            n_cmp++;
            if (door_open !== 1'b1 || weight_alert !== 1'b1) begin
                n_fail++; $display("FAIL door_held_%0d: got door=%b wa=%b required 1/1", k, door_open, weight_alert);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick('0, 1'b0, 1'b0);
            n_cmp++;
            if (door_open !== (k < 3) || weight_alert !== 1'b0) begin
                n_fail++; $display("FAIL door_release_%0d: got door=%b wa=%b required %b/0", k, door_open, weight_alert, (k < 3));
            end
        end
    endtask

    task automatic test_clear_on_entry();
        int cnt;
        start_at(4'd2);
        tick(9'h004, 1'b0, 1'b0);
        tick(9'h004, 1'b0, 1'b0);
        n_cmp++;
        if (door_open !== 1'b1 || pending !== 9'h000) begin
            n_fail++; $display("FAIL clear_wins: got door=%b pend=%h required 1/000", door_open, pending);
        end
        cnt = 1;
        for (int k = 0; k < 20 && door_open === 1'b1; k++) begin
            tick('0, 1'b0, 1'b0);
            if (door_open === 1'b1) cnt++;
        end
        n_cmp++;
        if (cnt !== DC) begin
            n_fail++; $display("FAIL clear_dwell: got %0d cycles required %0d", cnt, DC);
        end
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (door_open !== 1'b0 || pending !== 9'h000) begin
            n_fail++; $display("FAIL clear_no_reopen: got door=%b pend=%h required 0/000", door_open, pending);
        end
    endtask

    task automatic test_illegal_floor();
        start_at(4'd0);
        tick(9'h010, 1'b0, 1'b0);
        current_floor = 4'd12;
        tick('0, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_valid !== 1'b0 || dir_up !== 1'b0 || pending !== 9'h010) begin
            n_fail++; $display("FAIL illegal_hold: got tv=%b up=%b pend=%h required 0/0/010", target_valid, dir_up, pending);
        end
        current_floor = 4'd0;
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (target_valid !== 1'b1 || target_floor !== 4'd4) begin
            n_fail++; $display("FAIL illegal_recover: got tv=%b tgt=%0d required 1/4", target_valid, target_floor);
        end
    endtask

    task automatic test_mid_reset();
        start_at(4'd0);
        tick(9'h104, 1'b0, 1'b0);
        tick('0, 1'b0, 1'b0);
        n_cmp++;
        if (dir_up !== 1'b1 || pending !== 9'h104) begin
            n_fail++; $display("FAIL mid_reset_setup: got up=%b pend=%h required 1/104", dir_up, pending);
        end
        tick('0, 1'b0, 1'b1);
        n_cmp++;
        if ({target_floor, target_valid, dir_up, dir_down, door_open, weight_alert, pending} !== '0) begin
            n_fail++; $display("FAIL mid_reset: got tgt=%0d tv=%b up=%b dn=%b door=%b wa=%b pend=%h required all zero",
                               target_floor, target_valid, dir_up, dir_down, door_open, weight_alert, pending);
        end
    endtask

    task automatic test_random();
        logic [NF-1:0] c;
        logic          ow;
        logic          rst;
        logic [17:0]   act, exp;
        int            r;
        ow = 1'b0;
        start_at(FW'($urandom_range(0, NF - 1)));
        for (int cyc = 0; cyc < 3000; cyc++) begin
            c = '0;
            r = $urandom_range(0, 9);
            if (r < 2) c[$urandom_range(0, NF - 1)] = 1'b1;
            if (r == 0) c = c | NF'($urandom);
            if ($urandom_range(0, 24) == 0) ow = ~ow;
            rst = ($urandom_range(0, 799) == 0);
            tick(c, ow, rst);
            act = {target_floor, target_valid, dir_up, dir_down, door_open, weight_alert, pending};
            exp = {4'(m_tgt), m_tv, m_up, m_dn, m_door, m_wa, pend_vec()};
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                if (n_fail <= 30)
                    $display("FAIL random_cycle_%0d: got {tgt,tv,up,dn,door,wa,pend}=%h required %h floor=%0d",
                             cyc, act, exp, current_floor);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        call_req      = '0;
        over_weight   = 1'b0;
        current_floor = '0;
        model_reset();
        test_reset();
        test_single_call();
        test_enroute();
        test_reverse();
        test_over_weight();
        test_clear_on_entry();
        test_illegal_floor();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
